// File: rtl/ro_meas_sequencer_if.sv
// Result handshake between the ring-oscillator measurement sequencer and the
// averaging/UART consumer.
//   valid : result available (producer)
//   ready : consumer accepts the result (consumer)
//   data  : captured oscillator count, CNT_W bits (producer)
//   osc   : oscillator that produced data, 0 = inverter, 1 = NAND (producer)
//   ovf   : count saturated (producer, constant 0 unless overflow detect is built)
interface ro_meas_sequencer_if #(
    parameter int unsigned CNT_W = 16
);
    logic             valid;
    logic             ready;
    logic [CNT_W-1:0] data;
    logic             osc;
    logic             ovf;

    modport master (output valid, output data, output osc, output ovf, input ready);
    modport slave  (input valid, input data, input osc, input ovf, output ready);
endinterface

// File: rtl/ro_meas_sequencer.sv
// Autonomous measurement scheduler for the ring-oscillator temperature sensor.
// Each round powers up every oscillator selected in osc_mask in turn (inverter
// first), lets it settle, gates the external counter for gate_len cycles, waits
// for the count to resynchronise, captures it and offers it on the result
// handshake. The sequencer stalls in OUT until the result is taken.
//
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   start         : begin a round (sampled only while idle)
//   continuous    : start the next round automatically
//   stop          : synchronous abort from any state; discards a pending result
//   osc_mask      : bit0 inverter ring, bit1 NAND ring (latched per round)
//   gate_len      : gate window in cycles, 0 behaves as 1 (latched per round)
//   count_in      : oscillator counter value
//   en_inv_osc    : inverter ring enable
//   en_nand_osc   : NAND ring enable
//   osc_sel       : oscillator / counter source select
//   cnt_clr       : counter clear, first settle cycle only
//   cnt_en        : counter gate
//   busy          : high whenever not idle
//   res           : result handshake (master side)
//
// Build option: define RO_SEQ_OVF_EN to flag saturated counts on res.ovf.
module ro_meas_sequencer #(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned GATE_W     = 16,
    parameter int unsigned SETTLE_CYC = 8,
    parameter int unsigned SYNC_CYC   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               continuous,
    input  logic               stop,
    input  logic [1:0]         osc_mask,
    input  logic [GATE_W-1:0]  gate_len,
    input  logic [CNT_W-1:0]   count_in,
    output logic               en_inv_osc,
    output logic               en_nand_osc,
    output logic               osc_sel,
    output logic               cnt_clr,
    output logic               cnt_en,
    output logic               busy,
    ro_meas_sequencer_if.master res
);
    localparam int unsigned PH_MAX = (SETTLE_CYC > SYNC_CYC) ? SETTLE_CYC : SYNC_CYC;
    localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam logic [PH_W-1:0] SETTLE_LAST = PH_W'(SETTLE_CYC - 1);
    localparam logic [PH_W-1:0] SYNC_LAST   = PH_W'(SYNC_CYC - 1);

    typedef enum logic [2:0] {StIdle, StSettle, StGate, StSync, StCapture, StOut} state_e;

    state_e             state_q, state_d;
    logic               osc_q, osc_d;
    logic [1:0]         mask_q, mask_d;
    logic [GATE_W-1:0]  glen_q, glen_d;
    logic [GATE_W-1:0]  gcnt_q, gcnt_d;
    logic [PH_W-1:0]    ph_q, ph_d;
    logic               valid_q, valid_d;
    logic [CNT_W-1:0]   data_q, data_d;
    logic               rosc_q, rosc_d;
    logic               en_inv_q, en_nand_q, osc_sel_q, cnt_clr_q, cnt_en_q, busy_q;
    logic [GATE_W-1:0]  gate_last;
    logic               osc_on_d;

    // A zero gate length still opens the window for one cycle.
    assign gate_last = (glen_q == '0) ? '0 : glen_q - GATE_W'(1);

    always_comb begin
        state_d = state_q;
        osc_d   = osc_q;
        mask_d  = mask_q;
        glen_d  = glen_q;
        gcnt_d  = gcnt_q;
        ph_d    = ph_q;
        valid_d = valid_q;
        data_d  = data_q;
        rosc_d  = rosc_q;
        unique case (state_q)
            StIdle: begin
                if (start && osc_mask != 2'b00) begin
                    state_d = StSettle;
                    mask_d  = osc_mask;
                    glen_d  = gate_len;
                    osc_d   = ~osc_mask[0];
                    ph_d    = '0;
                end
            end
            StSettle: begin
                if (ph_q == SETTLE_LAST) begin
                    state_d = StGate;
                    ph_d    = '0;
                    gcnt_d  = '0;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            StGate: begin
                if (gcnt_q == gate_last) begin
                    state_d = StSync;
                    ph_d    = '0;
                end else begin
                    gcnt_d = gcnt_q + GATE_W'(1);
                end
            end
            StSync: begin
                if (ph_q == SYNC_LAST) begin
                    state_d = StCapture;
                    ph_d    = '0;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            StCapture: begin
                state_d = StOut;
                data_d  = count_in;
                rosc_d  = osc_q;
                valid_d = 1'b1;
            end
            StOut: begin
                if (valid_q && res.ready) begin
                    valid_d = 1'b0;
                    ph_d    = '0;
                    if (!osc_q && mask_q[1]) begin
                        state_d = StSettle;
                        osc_d   = 1'b1;
                    end else if (continuous && osc_mask != 2'b00) begin
                        state_d = StSettle;
                        mask_d  = osc_mask;
                        glen_d  = gate_len;
                        osc_d   = ~osc_mask[0];
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (stop) begin
            state_d = StIdle;
            valid_d = 1'b0;
            ph_d    = '0;
            gcnt_d  = '0;
        end
    end

    // Outputs are registered from the next state so they are glitch-free and
    // line up exactly with the state they describe.
    assign osc_on_d = (state_d == StSettle) || (state_d == StGate);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            osc_q     <= 1'b0;
            mask_q    <= 2'b00;
            glen_q    <= '0;
            gcnt_q    <= '0;
            ph_q      <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            rosc_q    <= 1'b0;
            en_inv_q  <= 1'b0;
            en_nand_q <= 1'b0;
            osc_sel_q <= 1'b0;
            cnt_clr_q <= 1'b0;
            cnt_en_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            osc_q     <= osc_d;
            mask_q    <= mask_d;
            glen_q    <= glen_d;
            gcnt_q    <= gcnt_d;
            ph_q      <= ph_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            rosc_q    <= rosc_d;
            en_inv_q  <= osc_on_d & ~osc_d;
            en_nand_q <= osc_on_d & osc_d;
            osc_sel_q <= (state_d != StIdle) & osc_d;
            cnt_clr_q <= (state_d == StSettle) && (state_q != StSettle);
            cnt_en_q  <= (state_d == StGate);
            busy_q    <= (state_d != StIdle);
        end
    end

`ifdef RO_SEQ_OVF_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (state_q == StCapture) begin
            ovf_d = &count_in;
        end
        if (!valid_d) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign res.ovf = ovf_q;
`else
    assign res.ovf = 1'b0;
`endif

    assign res.valid   = valid_q;
    assign res.data    = data_q;
    assign res.osc     = rosc_q;
    assign en_inv_osc  = en_inv_q;
    assign en_nand_osc = en_nand_q;
    assign osc_sel     = osc_sel_q;
    assign cnt_clr     = cnt_clr_q;
    assign cnt_en      = cnt_en_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_ro_meas_sequencer.sv
module tb_ro_meas_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        continuous = 1'b0;
    logic        stop = 1'b0;
    logic [1:0]  osc_mask = 2'b00;
    logic [15:0] gate_len = 16'd0;
    logic [15:0] count_in;
    logic        en_inv_osc, en_nand_osc, osc_sel, cnt_clr, cnt_en, busy;

    ro_meas_sequencer_if #(.CNT_W(16)) res_if ();

    ro_meas_sequencer #(
        .CNT_W(16), .GATE_W(16), .SETTLE_CYC(8), .SYNC_CYC(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous), .stop(stop),
        .osc_mask(osc_mask), .gate_len(gate_len), .count_in(count_in),
        .en_inv_osc(en_inv_osc), .en_nand_osc(en_nand_osc), .osc_sel(osc_sel),
        .cnt_clr(cnt_clr), .cnt_en(cnt_en), .busy(busy), .res(res_if.master)
    );

    always #5 clk = ~clk;

    // Oscillator counter model: counts one per gated cycle, cleared by cnt_clr.
    logic [15:0] cnt_model = 16'd0;
    logic        force_en = 1'b0;
    logic [15:0] force_val = 16'd0;
    always @(posedge clk) begin
        if (cnt_clr) cnt_model <= 16'd0;
        else if (cnt_en) cnt_model <= cnt_model + 16'd1;
    end
    assign count_in = force_en ? force_val : cnt_model;

    // Running activity totals; tests take differences against a snapshot.
    int inv_cyc = 0, nand_cyc = 0, overlap = 0, clr_cnt = 0, en_cyc = 0, valid_cyc = 0;
    int ovf_cyc = 0;
    bit          q_osc[$];
    logic [15:0] q_data[$];
    bit          q_ovf[$];
    always @(posedge clk) begin
        if (en_inv_osc) inv_cyc <= inv_cyc + 1;
        if (en_nand_osc) nand_cyc <= nand_cyc + 1;
        if (en_inv_osc && en_nand_osc) overlap <= overlap + 1;
        if (cnt_clr) clr_cnt <= clr_cnt + 1;
        if (cnt_en) en_cyc <= en_cyc + 1;
        if (res_if.valid) valid_cyc <= valid_cyc + 1;
        if (res_if.ovf) ovf_cyc <= ovf_cyc + 1;
        if (res_if.valid && res_if.ready) begin
            q_osc.push_back(res_if.osc);
            q_data.push_back(res_if.data);
            q_ovf.push_back(res_if.ovf);
        end
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic start_pulse();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (en_inv_osc !== 1'b0) begin n_fail++; $display("FAIL reset_en_inv: got %b want 0", en_inv_osc); end
        n_checks++; if (en_nand_osc !== 1'b0) begin n_fail++; $display("FAIL reset_en_nand: got %b want 0", en_nand_osc); end
        n_checks++; if (osc_sel !== 1'b0) begin n_fail++; $display("FAIL reset_osc_sel: got %b want 0", osc_sel); end
        n_checks++; if (cnt_clr !== 1'b0) begin n_fail++; $display("FAIL reset_cnt_clr: got %b want 0", cnt_clr); end
        n_checks++; if (cnt_en !== 1'b0) begin n_fail++; $display("FAIL reset_cnt_en: got %b want 0", cnt_en); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (res_if.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", res_if.valid); end
        n_checks++; if (res_if.data !== 16'd0) begin n_fail++; $display("FAIL reset_data: got %h want 0", res_if.data); end
        n_checks++; if (res_if.ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", res_if.ovf); end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_single();
        int b_inv, b_nand, b_clr, b_en, b_val, b_res;
        bit ok;
        b_inv = inv_cyc; b_nand = nand_cyc; b_clr = clr_cnt; b_en = en_cyc;
        b_val = valid_cyc; b_res = q_osc.size();
        osc_mask = 2'b01; gate_len = 16'd10; continuous = 1'b0; res_if.ready = 1'b1;
        start_pulse();
        wait_idle(200, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL single_timeout: busy=%b want 0", busy); end
        n_checks++; if (inv_cyc - b_inv != 18) begin n_fail++; $display("FAIL single_inv_cycles: got %0d want 18", inv_cyc - b_inv); end
        n_checks++; if (nand_cyc - b_nand != 0) begin n_fail++; $display("FAIL single_nand_cycles: got %0d want 0", nand_cyc - b_nand); end
        n_checks++; if (clr_cnt - b_clr != 1) begin n_fail++; $display("FAIL single_clr_pulses: got %0d want 1", clr_cnt - b_clr); end
        n_checks++; if (en_cyc - b_en != 10) begin n_fail++; $display("FAIL single_cnt_en_cycles: got %0d want 10", en_cyc - b_en); end
        n_checks++; if (valid_cyc - b_val != 1) begin n_fail++; $display("FAIL single_valid_cycles: got %0d want 1", valid_cyc - b_val); end
        n_checks++; if (q_osc.size() - b_res != 1) begin n_fail++; $display("FAIL single_results: got %0d want 1", q_osc.size() - b_res); end
        else begin
            n_checks++; if (q_osc[b_res] !== 1'b0) begin n_fail++; $display("FAIL single_res_osc: got %b want 0", q_osc[b_res]); end
            n_checks++; if (q_data[b_res] !== 16'd10) begin n_fail++; $display("FAIL single_res_data: got %0d want 10", q_data[b_res]); end
        end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_alternate();
        int b_inv, b_nand, b_ovl, b_res;
        bit ok;
        b_inv = inv_cyc; b_nand = nand_cyc; b_ovl = overlap; b_res = q_osc.size();
        osc_mask = 2'b11; gate_len = 16'd3; continuous = 1'b1; res_if.ready = 1'b1;
        start_pulse();
        // Drop continuous once the first NAND result of round two is the only one left.
        for (int i = 0; i < 400 && q_osc.size() - b_res < 3; i++) @(negedge clk);
        continuous = 1'b0;
        wait_idle(200, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL alt_timeout: busy=%b want 0", busy); end
        n_checks++; if (q_osc.size() - b_res != 4) begin n_fail++; $display("FAIL alt_results: got %0d want 4", q_osc.size() - b_res); end
        else begin
            for (int k = 0; k < 4; k++) begin
                n_checks++; if (q_osc[b_res+k] !== k[0]) begin n_fail++; $display("FAIL alt_res_osc[%0d]: got %b want %b", k, q_osc[b_res+k], k[0]); end
                n_checks++; if (q_data[b_res+k] !== 16'd3) begin n_fail++; $display("FAIL alt_res_data[%0d]: got %0d want 3", k, q_data[b_res+k]); end
            end
        end
        n_checks++; if (overlap - b_ovl != 0) begin n_fail++; $display("FAIL alt_overlap: got %0d want 0", overlap - b_ovl); end
        n_checks++; if (inv_cyc - b_inv != 22) begin n_fail++; $display("FAIL alt_inv_cycles: got %0d want 22", inv_cyc - b_inv); end
        n_checks++; if (nand_cyc - b_nand != 22) begin n_fail++; $display("FAIL alt_nand_cycles: got %0d want 22", nand_cyc - b_nand); end
    endtask

    task automatic test_backpressure();
        int b_clr, b_res;
        bit ok, seen;
        logic [15:0] held;
        b_res = q_osc.size();
        osc_mask = 2'b01; gate_len = 16'd5; continuous = 1'b0; res_if.ready = 1'b0;
        start_pulse();
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (res_if.valid) begin seen = 1'b1; break; end
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL bp_valid_timeout: valid=%b want 1", res_if.valid); end
        held = res_if.data;
        b_clr = clr_cnt;
        force_en = 1'b1;
        for (int i = 0; i < 50; i++) begin
            force_val = 16'(i * 37 + 1);
            @(negedge clk);
            n_checks++; if (res_if.valid !== 1'b1 || res_if.data !== held || busy !== 1'b1) begin
                n_fail++; $display("FAIL bp_stall[%0d]: valid=%b data=%h busy=%b want 1 %h 1", i, res_if.valid, res_if.data, busy, held);
            end
        end
        force_en = 1'b0;
        n_checks++; if (clr_cnt - b_clr != 0) begin n_fail++; $display("FAIL bp_clr_pulses: got %0d want 0", clr_cnt - b_clr); end
        res_if.ready = 1'b1;
        wait_idle(20, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_release_timeout: busy=%b want 0", busy); end
        n_checks++; if (q_osc.size() - b_res != 1) begin n_fail++; $display("FAIL bp_results: got %0d want 1", q_osc.size() - b_res); end
        else begin
            n_checks++; if (q_data[b_res] !== 16'd5) begin n_fail++; $display("FAIL bp_res_data: got %0d want 5", q_data[b_res]); end
        end
    endtask

    task automatic test_gate_zero();
        int b_en, b_res;
        bit ok;
        b_en = en_cyc; b_res = q_osc.size();
        osc_mask = 2'b10; gate_len = 16'd0; continuous = 1'b0; res_if.ready = 1'b1;
        start_pulse();
        wait_idle(100, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL gz_timeout: busy=%b want 0", busy); end
        n_checks++; if (en_cyc - b_en != 1) begin n_fail++; $display("FAIL gz_cnt_en_cycles: got %0d want 1", en_cyc - b_en); end
        n_checks++; if (q_osc.size() - b_res != 1) begin n_fail++; $display("FAIL gz_results: got %0d want 1", q_osc.size() - b_res); end
        else begin
            n_checks++; if (q_osc[b_res] !== 1'b1) begin n_fail++; $display("FAIL gz_res_osc: got %b want 1", q_osc[b_res]); end
            n_checks++; if (q_data[b_res] !== 16'd1) begin n_fail++; $display("FAIL gz_res_data: got %0d want 1", q_data[b_res]); end
        end
        // Empty mask: start must be ignored.
        osc_mask = 2'b00; gate_len = 16'd4;
        start_pulse();
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0 || en_inv_osc !== 1'b0 || en_nand_osc !== 1'b0) begin
            n_fail++; $display("FAIL mask0_idle: busy=%b inv=%b nand=%b want 0 0 0", busy, en_inv_osc, en_nand_osc);
        end
    endtask

    task automatic test_stop();
        int b_res, b_val;
        bit seen;
        b_res = q_osc.size(); b_val = valid_cyc;
        osc_mask = 2'b01; gate_len = 16'd20; continuous = 1'b0; res_if.ready = 1'b1;
        start_pulse();
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cnt_en) begin seen = 1'b1; break; end
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL stop_gate_timeout: cnt_en=%b want 1", cnt_en); end
        repeat (3) @(negedge clk);
        stop = 1'b1;
        @(negedge clk) stop = 1'b0;
        n_checks++; if (en_inv_osc !== 1'b0 || en_nand_osc !== 1'b0 || cnt_en !== 1'b0 || cnt_clr !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL stop_gate_outputs: inv=%b nand=%b en=%b clr=%b busy=%b want all 0", en_inv_osc, en_nand_osc, cnt_en, cnt_clr, busy);
        end
        repeat (40) @(negedge clk);
        n_checks++; if (valid_cyc - b_val != 0) begin n_fail++; $display("FAIL stop_gate_no_valid: got %0d want 0", valid_cyc - b_val); end
        // Abort with a pending result in OUT.
        res_if.ready = 1'b0; gate_len = 16'd2;
        start_pulse();
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (res_if.valid) begin seen = 1'b1; break; end
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL stop_out_valid_timeout: valid=%b want 1", res_if.valid); end
        stop = 1'b1;
        @(negedge clk) stop = 1'b0;
        n_checks++; if (res_if.valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL stop_out_discard: valid=%b busy=%b want 0 0", res_if.valid, busy);
        end
        res_if.ready = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++; if (q_osc.size() - b_res != 0) begin n_fail++; $display("FAIL stop_out_results: got %0d want 0", q_osc.size() - b_res); end
        // stop beats start in the same cycle.
        @(negedge clk) begin start = 1'b1; stop = 1'b1; end
        @(negedge clk) begin start = 1'b0; stop = 1'b0; end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stop_start_priority: busy=%b want 0", busy); end
    endtask

    task automatic test_async_reset();
        osc_mask = 2'b01; gate_len = 16'd10; res_if.ready = 1'b1;
        start_pulse();
        repeat (3) @(negedge clk);
        n_checks++; if (en_inv_osc !== 1'b1) begin n_fail++; $display("FAIL areset_pre_settle: inv=%b want 1", en_inv_osc); end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (en_inv_osc !== 1'b0 || en_nand_osc !== 1'b0 || osc_sel !== 1'b0 || busy !== 1'b0 || cnt_en !== 1'b0) begin
            n_fail++; $display("FAIL areset_outputs: inv=%b nand=%b sel=%b busy=%b en=%b want all 0", en_inv_osc, en_nand_osc, osc_sel, busy, cnt_en);
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL areset_stays_idle: busy=%b want 0", busy); end
    endtask

    task automatic test_ovf();
`ifdef RO_SEQ_OVF_EN
        int b_res;
        bit ok;
        osc_mask = 2'b01; gate_len = 16'd3; continuous = 1'b0; res_if.ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            b_res = q_osc.size();
            force_en = 1'b1;
            force_val = (k == 0) ? 16'hFFFF : 16'hFFFE;
            start_pulse();
            wait_idle(100, ok);
            n_checks++; if (!ok || q_osc.size() - b_res != 1) begin
                n_fail++; $display("FAIL ovf_round[%0d]: results=%0d want 1", k, q_osc.size() - b_res);
            end else begin
                n_checks++; if (q_ovf[b_res] !== (k == 0)) begin n_fail++; $display("FAIL ovf_flag[%0d]: got %b want %b", k, q_ovf[b_res], k == 0); end
            end
        end
        force_en = 1'b0;
        n_checks++; if (res_if.ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_cleared: got %b want 0", res_if.ovf); end
`else
        n_checks++; if (ovf_cyc != 0) begin n_fail++; $display("FAIL ovf_disabled: high cycles %0d want 0", ovf_cyc); end
`endif
    endtask

    initial begin
        res_if.ready = 1'b1;
        test_reset();
        test_single();
        test_alternate();
        test_backpressure();
        test_gate_zero();
        test_stop();
        test_async_reset();
        test_ovf();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
